// File: rtl/jolt80_mem_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module   : jolt80_mem_arbiter_if
//  Purpose  : Bundles the two requester ports, the shared memory port and the
//             arbiter status signals of jolt80_mem_arbiter.
//  Signals  : pN_req/addr/we/sz/wdata   requester N access request and payload
//             pN_rdy/pN_err             requester N completion / timeout pulses
//             rdata                     registered read data (shared)
//             mem_req/we/sz/addr/wdata  memory port request and payload
//             mem_ack/mem_rdata         memory completion strobe and read data
//             grant_id/busy             current owner / access in progress
//  Modports : slave  - arbiter side (serves requesters, drives the memory port)
//             master - environment side (requesters and memory model)
//  Revision : 1.0 - initial release
// ============================================================================
interface jolt80_mem_arbiter_if;
    logic        p0_req;
    logic [15:0] p0_addr;
    logic        p0_we;
    logic        p0_sz;
    logic [15:0] p0_wdata;
    logic        p0_rdy;
    logic        p0_err;

    logic        p1_req;
    logic [15:0] p1_addr;
    logic        p1_we;
    logic        p1_sz;
    logic [15:0] p1_wdata;
    logic        p1_rdy;
    logic        p1_err;

    logic [15:0] rdata;

    logic        mem_req;
    logic        mem_we;
    logic        mem_sz;
    logic [15:0] mem_addr;
    logic [15:0] mem_wdata;
    logic        mem_ack;
    logic [15:0] mem_rdata;

    logic        grant_id;
    logic        busy;

    modport slave (
        input  p0_req, p0_addr, p0_we, p0_sz, p0_wdata,
        output p0_rdy, p0_err,
        input  p1_req, p1_addr, p1_we, p1_sz, p1_wdata,
        output p1_rdy, p1_err,
        output rdata,
        output mem_req, mem_we, mem_sz, mem_addr, mem_wdata,
        input  mem_ack, mem_rdata,
        output grant_id, busy
    );

    modport master (
        output p0_req, p0_addr, p0_we, p0_sz, p0_wdata,
        input  p0_rdy, p0_err,
        output p1_req, p1_addr, p1_we, p1_sz, p1_wdata,
        input  p1_rdy, p1_err,
        input  rdata,
        input  mem_req, mem_we, mem_sz, mem_addr, mem_wdata,
        output mem_ack, mem_rdata,
        input  grant_id, busy
    );
endinterface
`default_nettype wire

// File: rtl/jolt80_mem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : jolt80_mem_arbiter
//  Purpose  : Two-port memory arbiter (port 0 = CPU, port 1 = secondary
//             master). One access at a time, with a per-access timeout that
//             aborts the access and pulses pN_err if mem_ack never arrives.
//  Ports    : clk    - clock, rising edge
//             reset  - synchronous, active-high reset
//             bus    - jolt80_mem_arbiter_if.slave (requesters, memory, status)
//  Params   : TIMEOUT_CYC - ACCESS cycles without mem_ack before abort (1..255)
//  Macros   : JOLT80_ARB_ROUND_ROBIN_EN - when defined, simultaneous requests
//             alternate between ports; otherwise port 0 always wins ties.
//  Revision : 1.0 - initial release
// ============================================================================
module jolt80_mem_arbiter #(
    parameter int unsigned TIMEOUT_CYC = 15
) (
    input  wire                  clk,
    input  wire                  reset,
    jolt80_mem_arbiter_if.slave  bus
);

    localparam logic [0:0] c_IDLE    = 1'b0;
    localparam logic [0:0] c_ACCESS  = 1'b1;
    localparam logic [7:0] c_TIMEOUT = 8'(TIMEOUT_CYC);

    logic [0:0]  state_q,     state_d;
    logic [7:0]  tmo_cnt_q,   tmo_cnt_d;
    logic        grant_q,     grant_d;
    logic        mem_we_q,    mem_we_d;
    logic        mem_sz_q,    mem_sz_d;
    logic [15:0] mem_addr_q,  mem_addr_d;
    logic [15:0] mem_wdata_q, mem_wdata_d;
    logic [15:0] rdata_q,     rdata_d;
    logic [1:0]  rdy_q,       rdy_d;
    logic [1:0]  err_q,       err_d;
`ifdef JOLT80_ARB_ROUND_ROBIN_EN
    logic        rr_last_q,   rr_last_d;
`endif

    logic [1:0]  w_req;
    logic        w_win;
    logic [7:0]  w_tmo_next;

    assign w_req      = {bus.p1_req, bus.p0_req};
    assign w_tmo_next = tmo_cnt_q + 8'd1;

    // Winner selection; only consulted in IDLE when at least one request is up.
`ifdef JOLT80_ARB_ROUND_ROBIN_EN
    // On a tie, the port that did not win the previous grant goes next.
    assign w_win = (&w_req) ? ~rr_last_q : w_req[1];
`else
    assign w_win = w_req[1] & ~w_req[0];
`endif

    always_comb begin
        state_d     = state_q;
        tmo_cnt_d   = tmo_cnt_q;
        grant_d     = grant_q;
        mem_we_d    = mem_we_q;
        mem_sz_d    = mem_sz_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        rdata_d     = rdata_q;
        rdy_d       = 2'b00;
        err_d       = 2'b00;
`ifdef JOLT80_ARB_ROUND_ROBIN_EN
        rr_last_d   = rr_last_q;
`endif
        case (state_q)
            c_IDLE: begin
                // mem_ack is deliberately not looked at here.
                if (|w_req) begin
                    state_d     = c_ACCESS;
                    tmo_cnt_d   = 8'd0;
                    grant_d     = w_win;
                    mem_addr_d  = w_win ? bus.p1_addr  : bus.p0_addr;
                    mem_we_d    = w_win ? bus.p1_we    : bus.p0_we;
                    mem_sz_d    = w_win ? bus.p1_sz    : bus.p0_sz;
                    mem_wdata_d = w_win ? bus.p1_wdata : bus.p0_wdata;
`ifdef JOLT80_ARB_ROUND_ROBIN_EN
                    rr_last_d   = w_win;
`endif
                end
            end
            c_ACCESS: begin
                // Ack is tested first so it wins over a same-edge timeout.
                if (bus.mem_ack) begin
                    state_d        = c_IDLE;
                    rdy_d[grant_q] = 1'b1;
                    if (!mem_we_q) begin
                        rdata_d = bus.mem_rdata;
                    end
                end else if (w_tmo_next == c_TIMEOUT) begin
                    state_d        = c_IDLE;
                    err_d[grant_q] = 1'b1;
                end else begin
                    tmo_cnt_d = w_tmo_next;
                end
            end
            default: begin
                state_d = c_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= c_IDLE;
            tmo_cnt_q   <= 8'd0;
            grant_q     <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_sz_q    <= 1'b1;
            mem_addr_q  <= 16'h0000;
            mem_wdata_q <= 16'h0000;
            rdata_q     <= 16'h0000;
            rdy_q       <= 2'b00;
            err_q       <= 2'b00;
`ifdef JOLT80_ARB_ROUND_ROBIN_EN
            rr_last_q   <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            tmo_cnt_q   <= tmo_cnt_d;
            grant_q     <= grant_d;
            mem_we_q    <= mem_we_d;
            mem_sz_q    <= mem_sz_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            rdata_q     <= rdata_d;
            rdy_q       <= rdy_d;
            err_q       <= err_d;
`ifdef JOLT80_ARB_ROUND_ROBIN_EN
            rr_last_q   <= rr_last_d;
`endif
        end
    end

    // The memory request is exactly the ACCESS state, so it drops on the
    // same edge that completes, times out or resets the access.
    assign bus.mem_req   = (state_q == c_ACCESS);
    assign bus.busy      = (state_q == c_ACCESS);
    assign bus.mem_we    = mem_we_q;
    assign bus.mem_sz    = mem_sz_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;
    assign bus.rdata     = rdata_q;
    assign bus.grant_id  = grant_q;
    assign bus.p0_rdy    = rdy_q[0];
    assign bus.p1_rdy    = rdy_q[1];
    assign bus.p0_err    = err_q[0];
    assign bus.p1_err    = err_q[1];

endmodule
`default_nettype wire

// File: tb/tb_jolt80_mem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_jolt80_mem_arbiter
//  Purpose  : Self-checking bench for jolt80_mem_arbiter: directed scenarios
//             with literal expectations, then randomized traffic compared
//             every cycle against a transaction-level reference model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_jolt80_mem_arbiter;

    localparam int TMO = 15;

    logic clk;
    logic reset;
    int   total = 0;
    int   bad   = 0;
    bit   chk_en = 1'b0;

    jolt80_mem_arbiter_if bus_if();

    jolt80_mem_arbiter #(.TIMEOUT_CYC(TMO)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk1(input string name, input logic act, input logic exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %b expected %b (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic chk16(input string name, input logic [15:0] act, input logic [15:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Reference model: tracks one outstanding transaction and the cycle
    // it was granted; the abort happens once TMO edges have passed
    // without an acknowledge.
    // ------------------------------------------------------------------
    int          cyc = 0;
    int          m_start = 0;
    bit          m_busy = 1'b0;
    bit          m_last = 1'b0;
    logic        e_grant, e_we, e_sz;
    logic [15:0] e_addr, e_wdata, e_rdata;
    logic [1:0]  e_rdy, e_err;

    always @(posedge clk) begin
        bit r0, r1, win;
        cyc++;
        r0 = bus_if.p0_req;
        r1 = bus_if.p1_req;
        if (reset) begin
            m_busy = 1'b0; m_last = 1'b0;
            e_grant = 1'b0; e_we = 1'b0; e_sz = 1'b1;
            e_addr = 16'h0; e_wdata = 16'h0; e_rdata = 16'h0;
            e_rdy = 2'b00; e_err = 2'b00;
        end else begin
            e_rdy = 2'b00;
            e_err = 2'b00;
            if (m_busy) begin
                if (bus_if.mem_ack) begin
                    e_rdy[e_grant] = 1'b1;
                    if (!e_we) e_rdata = bus_if.mem_rdata;
                    m_busy = 1'b0;
                end else if (cyc - m_start >= TMO) begin
                    e_err[e_grant] = 1'b1;
                    m_busy = 1'b0;
                end
            end else if (r0 || r1) begin
                if (r0 && r1) begin
`ifdef JOLT80_ARB_ROUND_ROBIN_EN
                    win = !m_last;
`else
                    win = 1'b0;
`endif
                end else begin
                    win = r1;
                end
                e_grant = win;
                e_addr  = win ? bus_if.p1_addr  : bus_if.p0_addr;
                e_we    = win ? bus_if.p1_we    : bus_if.p0_we;
                e_sz    = win ? bus_if.p1_sz    : bus_if.p0_sz;
                e_wdata = win ? bus_if.p1_wdata : bus_if.p0_wdata;
                m_last  = win;
                m_busy  = 1'b1;
                m_start = cyc;
            end
        end
    end

    // Compare process: every cycle, on the falling edge.
    always @(negedge clk) begin
        if (chk_en) begin
            chk1 ("mdl_mem_req",   bus_if.mem_req,   m_busy);
            chk1 ("mdl_busy",      bus_if.busy,      m_busy);
            chk1 ("mdl_grant_id",  bus_if.grant_id,  e_grant);
            chk1 ("mdl_mem_we",    bus_if.mem_we,    e_we);
            chk1 ("mdl_mem_sz",    bus_if.mem_sz,    e_sz);
            chk16("mdl_mem_addr",  bus_if.mem_addr,  e_addr);
            chk16("mdl_mem_wdata", bus_if.mem_wdata, e_wdata);
            chk16("mdl_rdata",     bus_if.rdata,     e_rdata);
            chk1 ("mdl_p0_rdy",    bus_if.p0_rdy,    e_rdy[0]);
            chk1 ("mdl_p1_rdy",    bus_if.p1_rdy,    e_rdy[1]);
            chk1 ("mdl_p0_err",    bus_if.p0_err,    e_err[0]);
            chk1 ("mdl_p1_err",    bus_if.p1_err,    e_err[1]);
        end
    end

    // ------------------------------------------------------------------
    // Stimulus helpers
    // ------------------------------------------------------------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        bus_if.p0_req = 1'b0; bus_if.p0_addr = 16'h0; bus_if.p0_we = 1'b0;
        bus_if.p0_sz  = 1'b0; bus_if.p0_wdata = 16'h0;
        bus_if.p1_req = 1'b0; bus_if.p1_addr = 16'h0; bus_if.p1_we = 1'b0;
        bus_if.p1_sz  = 1'b0; bus_if.p1_wdata = 16'h0;
        bus_if.mem_ack = 1'b0; bus_if.mem_rdata = 16'h0;
    endtask

    task automatic do_reset();
        clear_inputs();
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
    endtask

    task automatic chk_reset_values(input string tag);
        chk1 ({tag, "_mem_req"},   bus_if.mem_req,   1'b0);
        chk1 ({tag, "_busy"},      bus_if.busy,      1'b0);
        chk1 ({tag, "_mem_we"},    bus_if.mem_we,    1'b0);
        chk1 ({tag, "_mem_sz"},    bus_if.mem_sz,    1'b1);
        chk16({tag, "_mem_addr"},  bus_if.mem_addr,  16'h0000);
        chk16({tag, "_mem_wdata"}, bus_if.mem_wdata, 16'h0000);
        chk16({tag, "_rdata"},     bus_if.rdata,     16'h0000);
        chk1 ({tag, "_grant_id"},  bus_if.grant_id,  1'b0);
        chk1 ({tag, "_p0_rdy"},    bus_if.p0_rdy,    1'b0);
        chk1 ({tag, "_p0_err"},    bus_if.p0_err,    1'b0);
        chk1 ({tag, "_p1_rdy"},    bus_if.p1_rdy,    1'b0);
        chk1 ({tag, "_p1_err"},    bus_if.p1_err,    1'b0);
    endtask

    initial begin
        int   n;
        logic g_seen [3];
        logic g_exp  [3];
`ifdef JOLT80_ARB_ROUND_ROBIN_EN
        g_exp[0] = 1'b1; g_exp[1] = 1'b0; g_exp[2] = 1'b1;
`else
        g_exp[0] = 1'b0; g_exp[1] = 1'b0; g_exp[2] = 1'b0;
`endif
        reset = 1'b1;
        do_reset();
        chk_en = 1'b1;
        chk_reset_values("rst");

        // p0 8-bit read of 0x0010, ack one cycle after mem_req.
        bus_if.p0_req = 1'b1; bus_if.p0_addr = 16'h0010;
        bus_if.p0_we = 1'b0;  bus_if.p0_sz = 1'b0;
        step();
        chk1 ("rd_mem_req",  bus_if.mem_req,  1'b1);
        chk1 ("rd_busy",     bus_if.busy,     1'b1);
        chk16("rd_mem_addr", bus_if.mem_addr, 16'h0010);
        chk1 ("rd_grant",    bus_if.grant_id, 1'b0);
        bus_if.p0_req = 1'b0;
        bus_if.mem_ack = 1'b1; bus_if.mem_rdata = 16'hBEEF;
        step();
        bus_if.mem_ack = 1'b0;
        chk1 ("rd_p0_rdy",   bus_if.p0_rdy,   1'b1);
        chk1 ("rd_p0_err",   bus_if.p0_err,   1'b0);
        chk16("rd_rdata",    bus_if.rdata,    16'hBEEF);
        chk1 ("rd_req_drop", bus_if.mem_req,  1'b0);
        step();
        chk1 ("rd_rdy_1cyc", bus_if.p0_rdy,   1'b0);

        // p1 16-bit write of 0x1234 to 0x8000, ack after three cycles.
        bus_if.p1_req = 1'b1; bus_if.p1_addr = 16'h8000; bus_if.p1_we = 1'b1;
        bus_if.p1_sz = 1'b1;  bus_if.p1_wdata = 16'h1234;
        bus_if.mem_rdata = 16'hDEAD;
        step();
        bus_if.p1_req = 1'b0;
        for (int i = 0; i < 4; i++) begin
            chk1 ("wr_mem_req",   bus_if.mem_req,   1'b1);
            chk1 ("wr_mem_we",    bus_if.mem_we,    1'b1);
            chk1 ("wr_mem_sz",    bus_if.mem_sz,    1'b1);
            chk16("wr_mem_addr",  bus_if.mem_addr,  16'h8000);
            chk16("wr_mem_wdata", bus_if.mem_wdata, 16'h1234);
            chk1 ("wr_grant",     bus_if.grant_id,  1'b1);
            if (i == 3) bus_if.mem_ack = 1'b1;
            step();
        end
        bus_if.mem_ack = 1'b0;
        chk1 ("wr_p1_rdy",  bus_if.p1_rdy,  1'b1);
        chk1 ("wr_p0_rdy",  bus_if.p0_rdy,  1'b0);
        chk16("wr_rdata",   bus_if.rdata,   16'hBEEF);
        chk1 ("wr_req_low", bus_if.mem_req, 1'b0);
        step();

        // Three simultaneous requests straight after reset.
        do_reset();
        for (int t = 0; t < 3; t++) begin
            bus_if.p0_req = 1'b1; bus_if.p1_req = 1'b1;
            step();
            g_seen[t] = bus_if.grant_id;
            chk1("tie_mem_req", bus_if.mem_req, 1'b1);
            chk1("tie_grant", g_seen[t], g_exp[t]);
            bus_if.p0_req = 1'b0; bus_if.p1_req = 1'b0;
            bus_if.mem_ack = 1'b1;
            step();
            bus_if.mem_ack = 1'b0;
            chk1("tie_rdy", g_exp[t] ? bus_if.p1_rdy : bus_if.p0_rdy, 1'b1);
            step();
        end

        // Timeout: no acknowledge at all.
        bus_if.p0_req = 1'b1; bus_if.p0_we = 1'b0;
        step();
        bus_if.p0_req = 1'b0;
        n = 0;
        while (bus_if.mem_req && n < 40) begin
            chk1("tmo_no_rdy", bus_if.p0_rdy, 1'b0);
            chk1("tmo_no_err_early", bus_if.p0_err, 1'b0);
            n++;
            step();
        end
        chk16("tmo_len",     n[15:0],        16'd15);
        chk1 ("tmo_p0_err",  bus_if.p0_err,  1'b1);
        chk1 ("tmo_p0_rdy",  bus_if.p0_rdy,  1'b0);
        chk1 ("tmo_req_low", bus_if.mem_req, 1'b0);
        step();
        chk1 ("tmo_err_1cyc", bus_if.p0_err, 1'b0);
        bus_if.p1_req = 1'b1;
        step();
        bus_if.p1_req = 1'b0;
        chk1 ("tmo_next_req",   bus_if.mem_req,  1'b1);
        chk1 ("tmo_next_grant", bus_if.grant_id, 1'b1);
        bus_if.mem_ack = 1'b1;
        step();
        bus_if.mem_ack = 1'b0;
        chk1 ("tmo_next_rdy", bus_if.p1_rdy, 1'b1);
        step();

        // Reset two cycles into an access, ack arriving with the reset.
        bus_if.p0_req = 1'b1; bus_if.p0_addr = 16'h55AA; bus_if.p0_we = 1'b1;
        bus_if.p0_sz = 1'b0;  bus_if.p0_wdata = 16'h7777;
        step();
        bus_if.p0_req = 1'b0;
        step();
        chk1 ("rsta_mem_req", bus_if.mem_req, 1'b1);
        reset = 1'b1; bus_if.mem_ack = 1'b1;
        step();
        reset = 1'b0;
        chk_reset_values("rsta");
        step();
        bus_if.mem_ack = 1'b0;
        chk_reset_values("rsta_idle_ack");

        // Randomized traffic; the compare process checks every cycle.
        for (int i = 0; i < 3000; i++) begin
            bit quiet;
            quiet = ((i / 120) % 4) == 3;
            bus_if.p0_req   = ($urandom_range(0, 3) == 0);
            bus_if.p1_req   = ($urandom_range(0, 3) == 0);
            bus_if.p0_addr  = 16'($urandom);
            bus_if.p1_addr  = 16'($urandom);
            bus_if.p0_we    = 1'($urandom);
            bus_if.p1_we    = 1'($urandom);
            bus_if.p0_sz    = 1'($urandom);
            bus_if.p1_sz    = 1'($urandom);
            bus_if.p0_wdata = 16'($urandom);
            bus_if.p1_wdata = 16'($urandom);
            bus_if.mem_rdata = 16'($urandom);
            bus_if.mem_ack  = quiet ? 1'b0 : ($urandom_range(0, 4) == 0);
            reset           = ($urandom_range(0, 299) == 0);
            step();
        end
        clear_inputs();
        reset = 1'b0;
        step();
        step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/jolt80_mem_arbiter.md
JOLT80_MEM_ARBITER -- requirements
Module: jolt80_mem_arbiter

Interface
REQ-001 Parameter TIMEOUT_CYC, default 15, max ACCESS cycles awaiting mem_ack before abort (range 1..255).
REQ-002 clk  input  1  clock; all state changes on rising edge.
REQ-003 reset  input  1  reset, synchronous, active-high.
REQ-004 pN_req  input  1  requester N (N=0 CPU, N=1 secondary master) access request, level.
REQ-005 pN_addr  input  16  requester N byte address.
REQ-006 pN_we  input  1  requester N write enable (1=write, 0=read).
REQ-007 pN_sz  input  1  requester N access size (0=8-bit, 1=16-bit).
REQ-008 pN_wdata  input  16  requester N write data.
REQ-009 pN_rdy  output  1  one-cycle completion pulse to requester N.
REQ-010 pN_err  output  1  one-cycle timeout-abort pulse to requester N.
REQ-011 rdata  output  16  registered read data, shared by both requesters.
REQ-012 mem_req, mem_we, mem_sz  output  1 each  memory port request/write-enable/size.
REQ-013 mem_addr, mem_wdata  output  16 each  memory port address/write data.
REQ-014 mem_ack  input  1  memory completion strobe; mem_rdata  input  16  read data valid with mem_ack.
REQ-015 grant_id  output  1  owner of current/last access; busy  output  1  high in ACCESS.

Function
REQ-016 States SHALL be IDLE and ACCESS only.
REQ-017 IDLE: if any pN_req sampled high, SHALL latch winner's addr/we/sz/wdata into mem_* registers, set grant_id, assert mem_req and busy, enter ACCESS next edge.
REQ-018 Single-requester latency: req sampled edge N -> mem_req high after edge N; mem_ack at edge N+1 -> pN_rdy high for the cycle after edge N+1.
REQ-019 mem_addr/mem_we/mem_sz/mem_wdata SHALL hold stable for entire ACCESS state.
REQ-020 ACCESS with mem_ack high: capture mem_rdata into rdata on reads (rdata unchanged on writes), pulse owner's pN_rdy one cycle, drop mem_req and busy, return IDLE.
REQ-021 Timeout counter (8-bit) SHALL clear on ACCESS entry, increment each ACCESS cycle without mem_ack; reaching TIMEOUT_CYC: pulse owner's pN_err, drop mem_req, return IDLE, no pN_rdy.
REQ-022 mem_ack on the same edge the counter reaches TIMEOUT_CYC: ack SHALL win (rdy, no err).
REQ-023 mem_ack sampled in IDLE SHALL be ignored.
REQ-024 Requester dropping pN_req during ACCESS SHALL NOT abort the access; completion still pulses pN_rdy.
REQ-025 Non-owner request during ACCESS SHALL wait; no new grant before returning to IDLE (minimum one IDLE cycle between accesses).
REQ-026 pN_rdy and pN_err SHALL never both be high; at most one of p0/p1 outputs active per cycle.

Reset
REQ-027 On reset: state IDLE, mem_req=0, mem_we=0, mem_sz=1, mem_addr=0, mem_wdata=0, rdata=0, pN_rdy=0, pN_err=0, busy=0, grant_id=0, timeout counter=0, round-robin pointer=0.
REQ-028 Reset during ACCESS SHALL drop mem_req at that edge and suppress any pN_rdy/pN_err for the aborted access.

Configuration
REQ-029 Macro JOLT80_ARB_ROUND_ROBIN_EN defined: on simultaneous requests in IDLE, grant the port not granted last (pointer updated at each grant, reset 0 so port 1 wins first tie).
REQ-030 Macro undefined: fixed priority, port 0 always wins ties; pointer logic absent.

Verification
REQ-031 p0 read addr 0x0010, mem_ack 1 cycle after mem_req with mem_rdata 0xBEEF -> mem_addr 0x0010, p0_rdy pulse 1 cycle, rdata 0xBEEF, grant_id 0.
REQ-032 p1 16-bit write 0x1234 to 0x8000, ack after 3 cycles -> mem_we=1, mem_wdata 0x1234 stable 4 cycles, p1_rdy pulse, rdata unchanged.
REQ-033 p0 and p1 request same edge, repeated 3 times -> fixed: grants 0,0,0; with JOLT80_ARB_ROUND_ROBIN_EN: grants 1,0,1.
REQ-034 No mem_ack, TIMEOUT_CYC=15 -> p0_err pulse after 15 ACCESS cycles, mem_req low, no p0_rdy; next request granted normally.
REQ-035 Reset asserted 2 cycles into ACCESS, mem_ack next cycle -> mem_req low, no p0_rdy, all outputs at reset values.
